// File: rtl/trng_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | trng_pkg -- shared types and constants for the TRNG source controller |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package trng_pkg;

  localparam int SEL_W   = 2;
  localparam int NUM_SRC = 4;

  // Encoding is exported directly as the wrapper state on uio_out[1:0].
  typedef enum logic [1:0] {
    ST_FLUSH  = 2'b00,
    ST_WARMUP = 2'b01,
    ST_RUN    = 2'b10,
    ST_FAULT  = 2'b11
  } state_e;

  localparam logic [SEL_W-1:0] SRC_RO0 = 2'd0;
  localparam logic [SEL_W-1:0] SRC_RO1 = 2'd1;
  localparam logic [SEL_W-1:0] SRC_RO2 = 2'd2;
  localparam logic [SEL_W-1:0] SRC_RO3 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/trng_source_controller_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | trng_source_controller_if -- oscillator/unbiaser side signal bundle   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface trng_source_controller_if;
  import trng_pkg::*;

  logic [SEL_W-1:0]   src_sel;
  logic               bist_en;
  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC-1:0] src_bit;
  logic               req;
  logic               mux_valid;
  logic               mux_bit;
  logic               flush;
  logic               buf_req;
  logic [SEL_W-1:0]   active_sel;
  logic [1:0]         state;
  logic               fault;

  modport master (
    output src_sel, bist_en, src_valid, src_bit, req,
    input  mux_valid, mux_bit, flush, buf_req, active_sel, state, fault
  );

  modport slave (
    input  src_sel, bist_en, src_valid, src_bit, req,
    output mux_valid, mux_bit, flush, buf_req, active_sel, state, fault
  );

endinterface
`default_nettype wire

// File: rtl/trng_rct_health.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | trng_rct_health -- repetition-count health test on the selected bits  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module trng_rct_health #(
  parameter int RCT_CUTOFF = 32
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  clear,
  input  wire  en,
  input  wire  bit_valid,
  input  wire  data_bit,
  output logic trip
);

  localparam int CW = $clog2(RCT_CUTOFF + 1);
  localparam logic [CW-1:0] CUTOFF = CW'(RCT_CUTOFF);

  logic [CW-1:0] r_count;
  logic          r_last;

  // A zero count means no previous bit, so the first bit starts a run of one.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_count <= '0;
      r_last  <= 1'b0;
    end else if (bit_valid) begin
      r_last <= data_bit;
      if (r_count == '0 || data_bit != r_last) begin
        r_count <= CW'(1);
      end else if (r_count != CUTOFF) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign trip = en && (r_count == CUTOFF);

endmodule
`default_nettype wire

// File: rtl/trng_source_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | trng_source_controller -- entropy source select, flush/warm-up, RCT   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module trng_source_controller
  import trng_pkg::*;
#(
  parameter int NUM_SOURCES   = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int WARMUP_BITS   = 64,
  parameter int RCT_CUTOFF    = 32
) (
  input wire clk,
  input wire rst_n,
  trng_source_controller_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int WW = $clog2(WARMUP_BITS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WARMUP_LAST = WW'(WARMUP_BITS - 1);

  state_e           r_state, w_state_next;
  logic [SEL_W-1:0] r_active_sel;
  logic [SW-1:0]    r_settle, w_settle_next;
  logic [WW-1:0]    r_warm, w_warm_next;
  logic             r_mux_valid, r_mux_bit;
  logic             w_sel_change, w_sel_ok, w_bit_valid, w_bit, w_trip;

  assign w_sel_change = (bus.src_sel != r_active_sel);
  assign w_sel_ok     = (int'(r_active_sel) < NUM_SOURCES);
  assign w_bit_valid  = bus.src_valid[r_active_sel] && w_sel_ok;
  assign w_bit        = bus.src_bit[r_active_sel];

  trng_rct_health #(
    .RCT_CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (r_state == ST_FLUSH),
    .en        (bus.bist_en),
    .bit_valid (w_bit_valid),
    .data_bit  (w_bit),
    .trip      (w_trip)
  );

  // A source change outranks warm-up completion and RCT trips in every state.
  always_comb begin
    w_state_next  = r_state;
    w_settle_next = r_settle;
    w_warm_next   = r_warm;
    case (r_state)
      ST_FLUSH: begin
        if (w_sel_change) begin
          w_settle_next = '0;
        end else if (r_settle == SETTLE_LAST) begin
          w_state_next  = ST_WARMUP;
          w_settle_next = '0;
          w_warm_next   = '0;
        end else begin
          w_settle_next = r_settle + SW'(1);
        end
      end
      ST_WARMUP: begin
        if (w_sel_change) begin
          w_state_next  = ST_FLUSH;
          w_settle_next = '0;
        end else if (w_trip) begin
          w_state_next = ST_FAULT;
        end else if (w_bit_valid) begin
          if (r_warm == WARMUP_LAST) begin
            w_state_next = ST_RUN;
          end else begin
            w_warm_next = r_warm + WW'(1);
          end
        end
      end
      ST_RUN: begin
        if (w_sel_change) begin
          w_state_next  = ST_FLUSH;
          w_settle_next = '0;
        end else if (w_trip) begin
          w_state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (w_sel_change) begin
          w_state_next  = ST_FLUSH;
          w_settle_next = '0;
        end
      end
      default: w_state_next = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_FLUSH;
      r_settle <= '0;
      r_warm   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_settle <= w_settle_next;
      r_warm   <= w_warm_next;
    end
  end

  // Every state reloads on a mismatch, so the active select simply tracks src_sel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active_sel <= bus.src_sel;
      r_mux_valid  <= 1'b0;
      r_mux_bit    <= 1'b0;
    end else begin
      r_active_sel <= bus.src_sel;
      r_mux_valid  <= (r_state == ST_RUN) && (w_state_next == ST_RUN) && w_bit_valid;
      r_mux_bit    <= w_bit;
    end
  end

  assign bus.mux_valid  = r_mux_valid;
  assign bus.mux_bit    = r_mux_bit;
  assign bus.flush      = (r_state == ST_FLUSH) || (r_state == ST_FAULT);
  assign bus.buf_req    = bus.req && (r_state == ST_RUN);
  assign bus.active_sel = r_active_sel;
  assign bus.state      = r_state;
  assign bus.fault      = (r_state == ST_FAULT);

endmodule
`default_nettype wire

// File: doc/trng_source_controller.md
Name: trng_source_controller

Overview:
Sequences the TRNG entropy path. It selects one of four raw entropy sources and forwards that source's bit stream to the von Neumann unbiaser. On every source change it flushes the downstream unbiaser and vector buffer, then discards a warm-up window. With BIST enabled it runs a repetition-count health test on the selected stream and latches a fault. It sits between the four oscillators and the unbiaser/vector-buffer chain, and drives the 2-bit wrapper state exported on uio_out[1:0].

Parameters:
NUM_SOURCES, 4, number of entropy sources; the select width is fixed at 2 bits.
SETTLE_CYCLES, 16, number of clock cycles flush is held after a source change or reset; must be >= 1.
WARMUP_BITS, 64, number of valid source bits discarded before streaming; must be >= 1.
RCT_CUTOFF, 32, number of consecutive identical valid bits that declares a fault; must be >= 2.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
src_sel  in  2  requested entropy source (ui_in[2:1])
bist_en  in  1  enable repetition-count health test (ui_in[3])
src_valid  in  4  per-source bit-valid strobes
src_bit  in  4  per-source raw bits
req  in  1  user request for an 8-bit vector
mux_valid  out  1  selected bit valid, to the unbiaser
mux_bit  out  1  selected bit, to the unbiaser
flush  out  1  synchronous clear for the unbiaser and vector buffer
buf_req  out  1  gated request to the vector buffer
active_sel  out  2  source currently in use
state  out  2  wrapper state: 00 FLUSH, 01 WARMUP, 10 RUN, 11 FAULT
fault  out  1  health test failure latched

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=FLUSH, active_sel=src_sel, flush=1.
  - mux_valid=0, mux_bit=0, fault=0.
  - All counters cleared.
- Reset is synchronous and active-low. Asserting it at any point, including mid-RUN, restarts from FLUSH on the next edge.
- FLUSH:
  - flush=1, mux_valid=0, buf_req=0.
  - The settle counter increments each cycle. After SETTLE_CYCLES cycles in FLUSH, go to WARMUP.
  - If src_sel differs from active_sel: reload active_sel and restart the settle counter.
- WARMUP:
  - flush=0, mux_valid=0, buf_req=0.
  - Count cycles where src_valid[active_sel]=1. When the count reaches WARMUP_BITS, go to RUN.
  - The health test runs during WARMUP when bist_en=1.
- RUN:
  - mux_valid and mux_bit are registered copies of src_valid[active_sel] and src_bit[active_sel]; latency is exactly 1 cycle.
  - buf_req = req (combinational, gated by state==RUN).
- FAULT:
  - fault=1, flush=1, mux_valid=0, buf_req=0.
  - Exit only on a src_sel change (go to FLUSH with the new source, fault cleared) or on reset.
  - Deasserting bist_en does not clear FAULT.
- Source change in WARMUP or RUN: if src_sel != active_sel, go to FLUSH on the next edge and load active_sel. This takes priority over any simultaneous warm-up completion or RCT trip.
- Health test (RCT):
  - Compare each valid bit with the last valid bit; the run counter saturates at RCT_CUTOFF.
  - Equal bit: increment the counter. Different bit: set the counter to 1.
  - Counter reaching RCT_CUTOFF while bist_en=1 in WARMUP or RUN: go to FAULT next edge.
  - The counter is cleared in FLUSH.
  - With bist_en=0 the counter keeps running but never trips.
- Counter widths:
  - settle counter: clog2(SETTLE_CYCLES+1)
  - warm-up counter: clog2(WARMUP_BITS+1)
  - RCT counter: clog2(RCT_CUTOFF+1)
  - No wrap-around is permitted.

Decomposition:
- Shared package trng_pkg:
  - state encodings FLUSH/WARMUP/RUN/FAULT (2-bit)
  - source index constants for ring oscillator 0..3
  - SEL_W=2
- Sub-module trng_rct_health: inputs clk, rst_n, clear, en, bit_valid, bit; output trip.

Test Plan:
1. Reset; src_sel=0; src0 valid every cycle with alternating bits -> flush=1 for 16 cycles, state=01, then state=10 after 64 valid bits; mux_bit equals src_bit[0] delayed 1 cycle.
2. In RUN, change src_sel 0->2 -> next edge state=00, active_sel=2, mux_valid=0, flush=1 for 16 cycles, then a 64-bit warm-up on src2 before state=10.
3. bist_en=1; src1 stuck at 1, valid every cycle -> 32 cycles after RUN/WARMUP counting begins, state=11, fault=1, mux_valid=0; change src_sel to 3 -> state=00, fault=0.
4. bist_en=0 with the same stuck source -> stays in state=10 indefinitely, fault=0.
5. req=1 held from reset -> buf_req=0 during FLUSH and WARMUP, buf_req=1 in the first RUN cycle.
6. rst_n=0 for one edge mid-RUN -> next edge state=00, flush=1, fault=0, mux_valid=0, counters cleared; full settle and warm-up repeat.
